// File: rtl/time_manager.sv
// time_manager
//   Event scheduler for the emulated-time clock generators. Each pass scans
//   the NUM_CLK time_clock values one per cycle and keeps the earliest. If
//   that time does not pass stop_time, it is issued as time_next, and every
//   generator whose time equals it is flagged in hit. The block then waits
//   SETTLE_CYCLES cycles for the generators to advance before scanning again.
//   Supports free-run (run), single-step (step) and halt-at-stop_time.
//
// Ports
//   clk_sys      system clock
//   rst          synchronous active-high reset
//   run          level, free-run scheduling
//   step         1-cycle pulse, schedules one event when idle
//   stop_time    events later than this are not issued
//   time_clocks  packed generator times, entry k at [k*TIME_WIDTH +: TIME_WIDTH]
//   time_next    scheduled event time (all-ones after reset, never a real time)
//   issue        1-cycle pulse, coincident with the new time_next
//   hit          generators whose time equals time_next, stable until next issue
//   emu_time     time of the last issued event
//   event_count  number of issued events, wraps
//   halted       earliest time exceeded stop_time
//   err          sticky, an issued time was earlier than emu_time
module time_manager #(
    parameter int NUM_CLK       = 2,
    parameter int TIME_WIDTH    = 32,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                          clk_sys,
    input  logic                          rst,
    input  logic                          run,
    input  logic                          step,
    input  logic [TIME_WIDTH-1:0]         stop_time,
    input  logic [NUM_CLK*TIME_WIDTH-1:0] time_clocks,
    output logic [TIME_WIDTH-1:0]         time_next,
    output logic                          issue,
    output logic [NUM_CLK-1:0]            hit,
    output logic [TIME_WIDTH-1:0]         emu_time,
    output logic [31:0]                   event_count,
    output logic                          halted,
    output logic                          err
);

    // One counter serves both the scan index and the settle timer.
    localparam int CNT_W = $clog2(NUM_CLK + SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_CHECK, S_SETTLE, S_HALT
    } state_t;

    state_t state, state_nxt;

    logic [NUM_CLK-1:0][TIME_WIDTH-1:0] entry;
    logic [TIME_WIDTH-1:0]              scan_val;
    logic [TIME_WIDTH-1:0]              min_r;
    logic [TIME_WIDTH-1:0]              emu_plus1;
    logic [NUM_CLK-1:0]                 hit_nxt;
    logic [CNT_W-1:0]                   cnt;
    logic                               single_r;
    logic                               last_scan, settle_done;
    logic                               start_pass, do_issue, do_halt, leave_halt;

    assign entry       = time_clocks;
    assign last_scan   = (cnt == CNT_W'(NUM_CLK - 1));
    assign settle_done = (cnt == CNT_W'(SETTLE_CYCLES - 1));
    assign emu_plus1   = emu_time + TIME_WIDTH'(1);

    // Entry under the scan pointer this cycle.
    always_comb begin
        scan_val = entry[0];
        for (int k = 1; k < NUM_CLK; k++)
            if (cnt == CNT_W'(k)) scan_val = entry[k];
    end

    // Hit flags use the entries as seen in the CHECK cycle itself.
    for (genvar k = 0; k < NUM_CLK; k++) begin : g_hit
        assign hit_nxt[k] = (entry[k] == min_r);
    end

    always_ff @(posedge clk_sys) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        start_pass = 1'b0;
        do_issue   = 1'b0;
        do_halt    = 1'b0;
        leave_halt = 1'b0;
        case (state)
            S_IDLE: begin
                if (run || step) begin
                    state_nxt  = S_SCAN;
                    start_pass = 1'b1;
                end
            end
            S_SCAN: begin
                if (last_scan) state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (min_r > stop_time) begin
                    do_halt   = 1'b1;
                    state_nxt = S_HALT;
                end else begin
                    do_issue  = 1'b1;
                    state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_done) state_nxt = (run && !single_r) ? S_SCAN : S_IDLE;
            end
            S_HALT: begin
                // Leave when the operator lets go, or when stop_time has been
                // raised past the last issued event so the next run can proceed.
                if ((!run && !step) || (stop_time >= emu_plus1)) begin
                    leave_halt = 1'b1;
                    state_nxt  = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            time_next   <= '1;
            issue       <= 1'b0;
            hit         <= '0;
            emu_time    <= '0;
            event_count <= '0;
            halted      <= 1'b0;
            err         <= 1'b0;
            cnt         <= '0;
            min_r       <= '0;
            single_r    <= 1'b0;
        end else begin
            issue <= do_issue;

            if (state_nxt != state)
                cnt <= '0;
            else if (state == S_SCAN || state == S_SETTLE)
                cnt <= cnt + CNT_W'(1);

            if (start_pass) single_r <= step;

            // Strict less-than keeps the lowest index on ties.
            if (state == S_SCAN && (cnt == '0 || scan_val < min_r))
                min_r <= scan_val;

            if (do_issue) begin
                time_next   <= min_r;
                emu_time    <= min_r;
                event_count <= event_count + 32'd1;
                hit         <= hit_nxt;
                if (min_r < emu_time && event_count != '0) err <= 1'b1;
            end

            if (do_halt)         halted <= 1'b1;
            else if (leave_halt) halted <= 1'b0;
        end
    end

endmodule

// File: tb/tb_time_manager.sv
// Bench for time_manager: emulated clock generators, an event-level
// reference model, a per-cycle compare process and directed scenarios
// followed by randomized run/step/stop_time traffic.
module tb_time_manager;

    localparam int N  = 2;
    localparam int TW = 32;
    localparam int SC = 2;

    logic            clk_sys = 1'b0;
    logic            rst     = 1'b1;
    logic            run     = 1'b0;
    logic            step    = 1'b0;
    logic [TW-1:0]   stop_time = '0;
    logic [N*TW-1:0] time_clocks;
    logic [TW-1:0]   time_next;
    logic            issue;
    logic [N-1:0]    hit;
    logic [TW-1:0]   emu_time;
    logic [31:0]     event_count;
    logic            halted;
    logic            err;

    time_manager #(.NUM_CLK(N), .TIME_WIDTH(TW), .SETTLE_CYCLES(SC)) dut (
        .clk_sys     (clk_sys),
        .rst         (rst),
        .run         (run),
        .step        (step),
        .stop_time   (stop_time),
        .time_clocks (time_clocks),
        .time_next   (time_next),
        .issue       (issue),
        .hit         (hit),
        .emu_time    (emu_time),
        .event_count (event_count),
        .halted      (halted),
        .err         (err)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- emulated generators ----------------
    logic [TW-1:0] tc  [N];
    logic [TW-1:0] inc [N];
    logic [TW-1:0] ld  [N];
    logic          gen_load = 1'b1;

    initial for (int k = 0; k < N; k++) begin
        ld[k]  = '0;
        inc[k] = '0;
    end

    always @(posedge clk_sys) begin
        if (gen_load) begin
            for (int k = 0; k < N; k++) tc[k] <= ld[k];
        end else if (issue) begin
            for (int k = 0; k < N; k++) if (hit[k]) tc[k] <= tc[k] + inc[k];
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_pack
        assign time_clocks[k*TW +: TW] = tc[k];
    end

    // ---------------- reference model ----------------
    // Event-level: a pass started at edge e produces its decision at edge
    // e+N+1; after an issue the block is busy for SC more edges.
    localparam int P_READY = 0, P_PASS = 1, P_SETTLE = 2, P_HALT = 3;
    int            ph = P_READY;
    int            e = 0;
    int            due = 0;
    bit            single = 0;
    logic [TW-1:0] m_time_next, m_emu;
    logic [31:0]   m_count;
    logic [N-1:0]  m_hit;
    logic          m_issue, m_halted, m_err;

    always @(posedge clk_sys) begin
        logic [TW-1:0] mn;
        logic [TW-1:0] nxt_emu;
        e++;
        m_issue = 1'b0;
        if (rst) begin
            ph = P_READY; m_time_next = '1; m_emu = '0; m_count = '0;
            m_hit = '0; m_halted = 1'b0; m_err = 1'b0;
        end else begin
            case (ph)
                P_READY: if (run || step) begin
                    ph = P_PASS; single = step; due = e + N + 1;
                end
                P_PASS: if (e == due) begin
                    mn = tc[0];
                    for (int k = 1; k < N; k++) if (tc[k] < mn) mn = tc[k];
                    if (mn > stop_time) begin
                        m_halted = 1'b1; ph = P_HALT;
                    end else begin
                        if (mn < m_emu && m_count != 0) m_err = 1'b1;
                        m_time_next = mn; m_emu = mn; m_count++;
                        for (int k = 0; k < N; k++) m_hit[k] = (tc[k] == mn);
                        m_issue = 1'b1; ph = P_SETTLE; due = e + SC;
                    end
                end
                P_SETTLE: if (e == due) begin
                    if (run && !single) begin ph = P_PASS; due = e + N + 1; end
                    else ph = P_READY;
                end
                P_HALT: begin
                    nxt_emu = m_emu + 1;
                    if ((!run && !step) || stop_time >= nxt_emu) begin
                        ph = P_READY; m_halted = 1'b0;
                    end
                end
                default: ph = P_READY;
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    bit chk_en = 0;
    always @(negedge clk_sys) if (chk_en) begin
        check("issue",       64'(issue),       64'(m_issue));
        check("time_next",   64'(time_next),   64'(m_time_next));
        check("hit",         64'(hit),         64'(m_hit));
        check("emu_time",    64'(emu_time),    64'(m_emu));
        check("event_count", 64'(event_count), 64'(m_count));
        check("halted",      64'(halted),      64'(m_halted));
        check("err",         64'(err),         64'(m_err));
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        rst = 1'b1; run = 1'b0; step = 1'b0;
        @(negedge clk_sys);
        rst = 1'b0;
    endtask

    task automatic load(input logic [TW-1:0] a, input logic [TW-1:0] b,
                        input logic [TW-1:0] ia, input logic [TW-1:0] ib);
        ld[0] = a; ld[1] = b; inc[0] = ia; inc[1] = ib;
        gen_load = 1'b1;
        @(negedge clk_sys);
        gen_load = 1'b0;
    endtask

    task automatic pulse_step();
        step = 1'b1;
        @(negedge clk_sys);
        step = 1'b0;
    endtask

    logic [TW-1:0] seq_exp [5];
    logic [TW-1:0] seq_q   [$];
    int            n_iss;
    bit            pulsed;

    initial begin
        seq_exp[0] = 0; seq_exp[1] = 4; seq_exp[2] = 6; seq_exp[3] = 8; seq_exp[4] = 12;

        repeat (2) @(negedge clk_sys);
        chk_en = 1;
        check("rst_time_next", 64'(time_next), 64'(32'hFFFF_FFFF));
        check("rst_count",     64'(event_count), 64'd0);
        check("rst_issue",     64'(issue), 64'd0);
        rst = 1'b0;
        gen_load = 1'b0;

        // 1: basic pick of the smaller entry, 4 edges after run is seen
        load(5, 3, 0, 0);
        stop_time = 100;
        run = 1'b1;
        @(negedge clk_sys);
        run = 1'b0;
        repeat (3) @(negedge clk_sys);
        check("t1_issue", 64'(issue), 64'd1);
        check("t1_time",  64'(time_next), 64'd3);
        check("t1_hit",   64'(hit), 64'b10);
        check("t1_count", 64'(event_count), 64'd1);
        @(negedge clk_sys);
        check("t1_pulse", 64'(issue), 64'd0);
        repeat (4) @(negedge clk_sys);

        // 2: tie fires both with a single pulse
        do_reset();
        load(7, 7, 0, 0);
        n_iss = 0;
        run = 1'b1;
        @(negedge clk_sys);
        run = 1'b0;
        repeat (3) @(negedge clk_sys);
        check("t2_time", 64'(time_next), 64'd7);
        check("t2_hit",  64'(hit), 64'b11);
        for (int i = 0; i < 12; i++) begin
            n_iss += int'(issue);
            @(negedge clk_sys);
        end
        check("t2_issues", 64'(n_iss), 64'd1);

        // 3: free-run with stepping generators up to stop_time
        do_reset();
        load(0, 0, 4, 6);
        stop_time = 12;
        seq_q.delete();
        run = 1'b1;
        for (int i = 0; i < 200 && !halted; i++) begin
            @(negedge clk_sys);
            if (issue) seq_q.push_back(time_next);
        end
        check("t3_nevents", 64'(seq_q.size()), 64'd5);
        for (int i = 0; i < 5 && i < seq_q.size(); i++)
            check("t3_seq", 64'(seq_q[i]), 64'(seq_exp[i]));
        check("t3_halted", 64'(halted), 64'd1);
        check("t3_emu",    64'(emu_time), 64'd12);
        check("t3_next",   64'(time_next), 64'd12);
        repeat (5) @(negedge clk_sys);
        check("t3_hold", 64'(halted), 64'd1);
        stop_time = 20;  // resume past the halt point
        pulsed = 0;
        for (int i = 0; i < 30 && !pulsed; i++) begin
            @(negedge clk_sys);
            if (issue) pulsed = 1;
        end
        check("t3_resume", 64'(time_next), 64'd16);
        run = 1'b0;
        repeat (8) @(negedge clk_sys);

        // 4: single step; a step during SETTLE is ignored
        do_reset();
        load(10, 20, 1, 1);
        stop_time = 100;
        pulse_step();
        n_iss = 0; pulsed = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_sys);
            step = 1'b0;
            if (issue && !pulsed) begin step = 1'b1; pulsed = 1; end
            n_iss += int'(issue);
        end
        step = 1'b0;
        check("t4_issues", 64'(n_iss), 64'd1);
        check("t4_emu",    64'(emu_time), 64'd10);

        // 5: backwards time sets sticky err
        do_reset();
        load(8, 50, 0, 0);
        pulse_step();
        repeat (8) @(negedge clk_sys);
        check("t5_emu8", 64'(emu_time), 64'd8);
        check("t5_err0", 64'(err), 64'd0);
        load(2, 50, 0, 0);
        pulse_step();
        repeat (8) @(negedge clk_sys);
        check("t5_err1", 64'(err), 64'd1);
        load(30, 50, 0, 0);
        pulse_step();
        repeat (8) @(negedge clk_sys);
        check("t5_sticky", 64'(err), 64'd1);
        do_reset();
        check("t5_clear", 64'(err), 64'd0);

        // 6: reset mid-SCAN and mid-SETTLE
        load(0, 0, 3, 5);
        stop_time = 1000;
        run = 1'b1;
        @(negedge clk_sys);
        rst = 1'b1;
        @(negedge clk_sys);
        rst = 1'b0; run = 1'b0;
        check("t6_scan_next",  64'(time_next), 64'(32'hFFFF_FFFF));
        check("t6_scan_count", 64'(event_count), 64'd0);
        n_iss = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_sys);
            n_iss += int'(issue);
        end
        check("t6_scan_idle", 64'(n_iss), 64'd0);
        run = 1'b1;
        pulsed = 0;
        for (int i = 0; i < 12 && !pulsed; i++) begin
            @(negedge clk_sys);
            if (issue) pulsed = 1;
        end
        check("t6_reached_settle", 64'(pulsed), 64'd1);
        rst = 1'b1;
        @(negedge clk_sys);
        rst = 1'b0; run = 1'b0;
        check("t6_set_next",  64'(time_next), 64'(32'hFFFF_FFFF));
        check("t6_set_emu",   64'(emu_time), 64'd0);
        check("t6_set_hit",   64'(hit), 64'd0);
        n_iss = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_sys);
            n_iss += int'(issue);
        end
        check("t6_set_idle", 64'(n_iss), 64'd0);

        // randomized run/step/stop_time traffic, checked every cycle
        for (int it = 0; it < 8; it++) begin
            do_reset();
            load($urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(1, 6), $urandom_range(1, 6));
            stop_time = $urandom_range(5, 60);
            for (int c = 0; c < 300; c++) begin
                @(negedge clk_sys);
                run  = ($urandom_range(0, 9) < 7);
                step = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 19) == 0) stop_time = stop_time + $urandom_range(0, 8);
            end
            run = 1'b0; step = 1'b0;
            repeat (8) @(negedge clk_sys);
        end

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
